// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch into a DEPTH-entry
// PC/instruction queue, with EX redirects that flush the queue and drop in-flight words.
module fetch_queue #(
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [DATA_W-1:0]            imem_rdata,
    output logic                         id_valid,
    output logic [DATA_W-1:0]            id_inst,
    output logic [ADDR_W-1:0]            id_pc,
    input  logic                         id_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DATA_W-1:0] inst_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];

    logic [CNT_W:0]    credit;
    logic              req;
    logic              fire;
    logic              push;
    logic              pop;

    // Words still owed to the queue; counting them up front means a push never overflows.
    always_comb begin
        credit = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_cnt_q};
        req    = !redirect && (inflight_q < CNT_W'(MAX_OUT)) && (credit < (CNT_W+1)'(DEPTH));
        fire   = req && imem_gnt;
        push   = imem_rvalid && (drop_cnt_q == '0) && !redirect;
        pop    = (count_q != '0) && id_ready && !redirect;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        inflight_d = inflight_q + CNT_W'(fire) - CNT_W'(imem_rvalid);
        drop_cnt_d = drop_cnt_q;
        inst_d     = inst_q;
        pc_d       = pc_q;

        if (fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
        if (imem_rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
        if (push) begin
            inst_d[wr_ptr_q] = imem_rdata;
            pc_d[wr_ptr_q]   = resp_pc_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            resp_pc_d        = resp_pc_q + ADDR_W'(4);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Everything still outstanding after this cycle's response belongs to the old path.
        if (redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_cnt_d = inflight_q - CNT_W'(imem_rvalid);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Queue storage needs no reset: id_valid masks stale entries.
    always_ff @(posedge clk) begin
        inst_q <= inst_d;
        pc_q   <= pc_d;
    end

    assign imem_req  = reset && req;
    assign imem_addr = fetch_pc_q;
    assign id_valid  = reset && (count_q != '0);
    assign id_inst   = inst_q[rd_ptr_q];
    assign id_pc     = pc_q[rd_ptr_q];
    assign occupancy = reset ? count_q : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirects with drops,
// mid-stream reset and address wrap, against an in-order variable-latency imem model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    int lat      = 1;
    int edge_n   = 0;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } mreq_t;
    mreq_t mq[$];

    fetch_queue #(
        .DEPTH   (4),
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_OUT (2),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_ready   (id_ready),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // In-order pipelined memory: a grant at edge e is answered in the cycle after edge e+lat-1.
    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            imem_rvalid <= 1'b0;
        end else begin
            if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, rdy: edge_n + lat - 1});
            if (mq.size() > 0 && mq[0].rdy <= edge_n) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
        edge_n++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 64'(id_valid), 64'(1'b1));
        check({tag, "_pc"},    64'(id_pc),    64'(pc));
        check({tag, "_inst"},  64'(id_inst),  64'(word_of(pc)));
    endtask

    initial begin
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; id_ready = 1'b0;

        // Reset held low
        tick; tick;
        check("rst_req",   64'(imem_req),  64'(0));
        check("rst_valid", 64'(id_valid),  64'(0));
        check("rst_occ",   64'(occupancy), 64'(0));
        check("rst_addr",  64'(imem_addr), 64'(0));

        // 1: streaming with 1-cycle memory
        reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; lat = 1;
        #1;
        check("s_req0",  64'(imem_req),  64'(1));
        check("s_addr0", 64'(imem_addr), 64'(0));
        for (int k = 1; k <= 8; k++) begin
            tick;
            check($sformatf("s_addr%0d", k), 64'(imem_addr), 64'(4 * k));
            if (k >= 2) check_head($sformatf("s_head%0d", k), 32'(4 * (k - 2)));
            else        check("s_valid1", 64'(id_valid), 64'(0));
        end

        // 2: back-pressure fills the queue, then drains in order
        id_ready = 1'b0;
        for (int k = 9; k <= 17; k++) begin
            tick;
            if (k >= 10) begin
                check($sformatf("bp_occ%0d", k), 64'(occupancy), 64'(k == 10 ? 3 : 4));
                check($sformatf("bp_req%0d", k), 64'(imem_req),  64'(0));
            end
        end
        tick;
        check("bp_occ18", 64'(occupancy), 64'(4));
        check_head("bp_head18", 32'd24);
        id_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick;
            check_head($sformatf("drain%0d", i), 32'(24 + 4 * i));
        end

        // 3: redirect with two requests in flight (3-cycle memory)
        tick; imem_gnt = 1'b0;
        tick; tick; tick;
        check("idle_occ",  64'(occupancy), 64'(0));
        check("idle_addr", 64'(imem_addr), 64'(68));
        imem_gnt = 1'b1; lat = 3;
        tick; tick;
        check("r3_req_full", 64'(imem_req), 64'(0));
        redirect = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect = 1'b0;
        check("r3_addr", 64'(imem_addr), 64'(32'h40));
        check("r3_occ",  64'(occupancy), 64'(0));
        for (int k = 33; k <= 36; k++) begin
            tick;
            check($sformatf("r3_drop%0d", k), 64'(id_valid), 64'(0));
        end
        tick;
        check_head("r3_first", 32'h40);
        check("r3_occ1", 64'(occupancy), 64'(1));

        // 4: redirect coinciding with a response and a pop
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        check("r4_req_redir", 64'(imem_req), 64'(0));
        tick;
        redirect = 1'b0;
        #1;
        check("r4_occ",   64'(occupancy), 64'(0));
        check("r4_valid", 64'(id_valid),  64'(0));
        check("r4_addr",  64'(imem_addr), 64'(32'h100));
        check("r4_req",   64'(imem_req),  64'(1));
        for (int k = 39; k <= 41; k++) begin
            tick;
            check($sformatf("r4_drop%0d", k), 64'(id_valid), 64'(0));
        end
        tick;
        check_head("r4_first", 32'h100);

        // 5: reset mid-stream at occupancy 3
        id_ready = 1'b0; lat = 1;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (occupancy == 3'd3) break;
        end
        check("r5_occ3", 64'(occupancy), 64'(3));
        check_head("r5_head", 32'h100);
        reset = 1'b0;
        tick;
        check("r5_valid", 64'(id_valid),  64'(0));
        check("r5_occ",   64'(occupancy), 64'(0));
        check("r5_req",   64'(imem_req),  64'(0));
        check("r5_addr",  64'(imem_addr), 64'(0));

        // 6: fetch address wraps past 0xFFFFFFFC
        reset = 1'b1; id_ready = 1'b1; imem_gnt = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        #1;
        check("w_req_redir", 64'(imem_req), 64'(0));
        tick;
        redirect = 1'b0;
        #1;
        check("w_addr0", 64'(imem_addr), 64'(32'hFFFF_FFF8));
        check("w_req0",  64'(imem_req),  64'(1));
        tick;
        check("w_addr1", 64'(imem_addr), 64'(32'hFFFF_FFFC));
        tick;
        check("w_addr2", 64'(imem_addr), 64'(32'h0));
        check_head("w_head0", 32'hFFFF_FFF8);
        tick;
        check("w_addr3", 64'(imem_addr), 64'(32'h4));
        check_head("w_head1", 32'hFFFF_FFFC);
        tick;
        check_head("w_head2", 32'h0);
        tick;
        check_head("w_head3", 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
